imem_loader: RTL

Boot-time program loader that fills instruction memory over a byte-serial valid/ready stream while holding the MIPS core in reset. It writes the instruction store that the core's fetch path only reads, and sits between an external byte source (UART receiver, test harness) and the instruction memory write port. On successful load it releases the core so execution starts from address 0.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte-serial stream -> 32-bit imem writes, core held in reset until done.
// Optional checksum byte after the data is enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset, core held in reset
// HDR     | accepting header byte N (word count)
// DATA    | accepting 4*N data bytes, MSB first
// CSUM    | accepting XOR checksum byte (IMEM_LOADER_CHECKSUM_EN only)
// FLUSH   | one cycle for the final write to land
// DONE    | load complete, core released
// ERR     | bad header or checksum, core held in reset
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [31:0]      asm_q, asm_d;
  logic             rx_ready_q, rx_ready_d;
  logic             imem_we_q, imem_we_d;
  logic [31:0]      imem_addr_q, imem_addr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             xfer;
  state_t           end_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign end_state = S_CSUM;
`else
  assign end_state = S_FLUSH;
`endif

  // rx_ready_q is the registered handshake output, so it also qualifies the transfer
  assign xfer = rx_valid && rx_ready_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    n_d          = n_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = rx_data;
`endif
          if (rx_data == 8'd0) begin
            state_d = end_state;
          end else if ({24'd0, rx_data} > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            n_d     = rx_data[CNT_W-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = {{(30-CNT_W){1'b0}}, word_idx_q, 2'b00};
            imem_wdata_d = asm_d;
            word_idx_d   = word_idx_q + CNT_W'(1);
            if (word_idx_d == n_q) state_d = end_state;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_FLUSH : S_ERR;
      end
`endif
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they line up with state_q
    rx_ready_d  = (state_d == S_HDR) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    rx_ready_d  = rx_ready_d || (state_d == S_CSUM);
`endif
    busy_d      = rx_ready_d || (state_d == S_FLUSH);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= '0;
      n_q          <= '0;
      asm_q        <= 32'd0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      n_q          <= n_d;
      asm_q        <= asm_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = word_idx_q;

endmodule
